// File: rtl/melody_pkg.sv
// Shared types for the melody sequencer: song entry layout, tone codes,
// FSM states and the default song table.
package melody_pkg;

  typedef struct packed {
    logic       rest;
    logic [2:0] tone;
    logic [2:0] beats;
  } note_t;

  localparam logic [2:0] DO_LO = 3'd0;
  localparam logic [2:0] RE    = 3'd1;
  localparam logic [2:0] MI    = 3'd2;
  localparam logic [2:0] FA    = 3'd3;
  localparam logic [2:0] SO    = 3'd4;
  localparam logic [2:0] LA    = 3'd5;
  localparam logic [2:0] TI    = 3'd6;
  localparam logic [2:0] DO_HI = 3'd7;

  typedef enum logic [1:0] {IDLE, NOTE, GAP} state_t;

  // Scale up do..DO, then back down DO..do, two beats per note.
  localparam note_t [0:15] SONG = '{
    '{1'b0, DO_LO, 3'd2}, '{1'b0, RE,    3'd2}, '{1'b0, MI,    3'd2}, '{1'b0, FA,    3'd2},
    '{1'b0, SO,    3'd2}, '{1'b0, LA,    3'd2}, '{1'b0, TI,    3'd2}, '{1'b0, DO_HI, 3'd2},
    '{1'b0, DO_HI, 3'd2}, '{1'b0, TI,    3'd2}, '{1'b0, LA,    3'd2}, '{1'b0, SO,    3'd2},
    '{1'b0, FA,    3'd2}, '{1'b0, MI,    3'd2}, '{1'b0, RE,    3'd2}, '{1'b0, DO_LO, 3'd2}
  };

  // A zero-beat entry still plays for one beat.
  function automatic logic [2:0] beats_of(note_t n);
    return (n.beats == 3'd0) ? 3'd1 : n.beats;
  endfunction

endpackage

// File: rtl/melody_sequencer_if.sv
// Control and tone-select bundle between the sequencer and its user / the organ.
interface melody_sequencer_if;
  import melody_pkg::*;

  // start is a one-cycle request accepted only while busy=0 (not queued);
  // done is a one-cycle completion strobe; stop is a level abort with priority.
  logic       start;
  logic       stop;
  logic       loop_en;
  logic [2:0] sel;
  logic       note_on;
  logic       busy;
  logic       done;
  logic [3:0] note_idx;
  state_t     state;

  modport slave (
    input  start, stop, loop_en,
    output sel, note_on, busy, done, note_idx, state
  );

  modport master (
    output start, stop, loop_en,
    input  sel, note_on, busy, done, note_idx, state
  );
endinterface

// File: rtl/melody_sequencer_beat_timer.sv
// Loadable down-counter; expired is high while the count sits at zero.
module beat_timer #(
  parameter int W = 8
) (
  input  logic         inclk,
  input  logic         reset,
  input  logic         clear,
  input  logic         load,
  input  logic [W-1:0] load_value,
  output logic         expired
);

  logic [W-1:0] count;

  always_ff @(posedge inclk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign expired = (count == '0);

endmodule

// File: rtl/melody_sequencer.sv
// Steps through a song table, holding each tone for its beat count and
// following it with a silent gap; drives the organ's 3-bit tone select.
module melody_sequencer
  import melody_pkg::*;
#(
  parameter int           BEAT_CYCLES = 12_500_000,
  parameter int           GAP_CYCLES  = 1_250_000,
  parameter int           SONG_LEN    = 16,
  parameter note_t [0:15] SONG_TABLE  = SONG
) (
  input logic               inclk,
  input logic               reset,
  melody_sequencer_if.slave bus
);

  localparam int CW = $clog2(7 * BEAT_CYCLES + 1);
  localparam logic [CW-1:0] GAP_LOAD = CW'(GAP_CYCLES - 1);
  localparam logic [3:0]    LAST_IDX = 4'(SONG_LEN - 1);

  state_t     state, state_n;
  logic [2:0] sel_q, sel_n;
  logic       note_on_q, note_on_n;
  logic       busy_q, busy_n;
  logic       done_q, done_n;
  logic [3:0] idx_q, idx_n;

  logic          tmr_clear, tmr_load, tmr_expired;
  logic [CW-1:0] tmr_load_value;
  logic          launch;
  logic [3:0]    launch_idx;
  note_t         launch_entry;

  beat_timer #(.W(CW)) u_timer (
    .inclk      (inclk),
    .reset      (reset),
    .clear      (tmr_clear),
    .load       (tmr_load),
    .load_value (tmr_load_value),
    .expired    (tmr_expired)
  );

  always_ff @(posedge inclk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      sel_q     <= 3'd0;
      note_on_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      idx_q     <= 4'd0;
    end else begin
      state     <= state_n;
      sel_q     <= sel_n;
      note_on_q <= note_on_n;
      busy_q    <= busy_n;
      done_q    <= done_n;
      idx_q     <= idx_n;
    end
  end

  always_comb begin
    state_n        = state;
    sel_n          = sel_q;
    note_on_n      = note_on_q;
    done_n         = 1'b0;
    idx_n          = idx_q;
    tmr_clear      = 1'b0;
    tmr_load       = 1'b0;
    tmr_load_value = '0;
    launch         = 1'b0;
    launch_idx     = 4'd0;

    if (bus.stop) begin
      state_n   = IDLE;
      note_on_n = 1'b0;
      idx_n     = 4'd0;
      tmr_clear = 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            launch     = 1'b1;
            launch_idx = 4'd0;
          end
        end
        NOTE: begin
          if (tmr_expired) begin
            state_n        = GAP;
            note_on_n      = 1'b0;
            tmr_load       = 1'b1;
            tmr_load_value = GAP_LOAD;
          end
        end
        GAP: begin
          if (tmr_expired) begin
            if (idx_q < LAST_IDX) begin
              launch     = 1'b1;
              launch_idx = idx_q + 4'd1;
            end else if (bus.loop_en) begin
              launch     = 1'b1;
              launch_idx = 4'd0;
            end else begin
              state_n = IDLE;
              done_n  = 1'b1;
              idx_n   = 4'd0;
            end
          end
        end
        default: state_n = IDLE;
      endcase
    end

    // Entry lookup feeds sel/note_on on the same edge that enters NOTE.
    launch_entry = SONG_TABLE[launch_idx];
    if (launch) begin
      state_n        = NOTE;
      idx_n          = launch_idx;
      sel_n          = launch_entry.tone;
      note_on_n      = ~launch_entry.rest;
      tmr_load       = 1'b1;
      tmr_load_value = CW'(beats_of(launch_entry)) * CW'(BEAT_CYCLES) - CW'(1);
    end

    busy_n = (state_n != IDLE);
  end

  assign bus.sel      = sel_q;
  assign bus.note_on  = note_on_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.note_idx = idx_q;
  assign bus.state    = state;

endmodule
